// File: rtl/matrix_mem_pkg.sv
// matrix_mem_pkg: shared types and helpers for the matrix_mem_rc block.
// Optional clear engine is enabled by defining MATRIX_CLEAR_EN.
package matrix_mem_pkg;
  typedef enum logic { IDLE = 1'b0, STREAM = 1'b1 } burst_state_t;
  typedef enum logic { ROW_MODE = 1'b0, COL_MODE = 1'b1 } burst_mode_t;

  // Address width that never collapses to zero for a single row/column.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/matrix_mem_rc_if.sv
// matrix_mem_rc_if: element port + burst stream bundle.
// clear_req/clear_busy exist only when MATRIX_CLEAR_EN is defined.
interface matrix_mem_rc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 10,
  parameter int COLS       = 10
);
  import matrix_mem_pkg::*;
  localparam int RA_W = clog2_min1(ROWS);
  localparam int CA_W = clog2_min1(COLS);
  localparam int IW   = (RA_W > CA_W) ? RA_W : CA_W;

  logic                  en_WriteMat, en_ReadMat;
  logic [RA_W-1:0]       rowAddr;
  logic [CA_W-1:0]       colAddr;
  logic [DATA_WIDTH-1:0] writeData, readData, burst_data;
  logic                  readValid, access_err;
  logic                  burst_start, burst_mode, burst_ready;
  logic [IW-1:0]         burst_idx;
  logic                  burst_valid, burst_last, burst_busy;
`ifdef MATRIX_CLEAR_EN
  logic                  clear_req, clear_busy;

  modport master (
    output en_WriteMat, en_ReadMat, rowAddr, colAddr, writeData,
           burst_start, burst_mode, burst_idx, burst_ready, clear_req,
    input  readData, readValid, access_err, burst_data, burst_valid,
           burst_last, burst_busy, clear_busy
  );
  modport slave (
    input  en_WriteMat, en_ReadMat, rowAddr, colAddr, writeData,
           burst_start, burst_mode, burst_idx, burst_ready, clear_req,
    output readData, readValid, access_err, burst_data, burst_valid,
           burst_last, burst_busy, clear_busy
  );
`else
  modport master (
    output en_WriteMat, en_ReadMat, rowAddr, colAddr, writeData,
           burst_start, burst_mode, burst_idx, burst_ready,
    input  readData, readValid, access_err, burst_data, burst_valid,
           burst_last, burst_busy
  );
  modport slave (
    input  en_WriteMat, en_ReadMat, rowAddr, colAddr, writeData,
           burst_start, burst_mode, burst_idx, burst_ready,
    output readData, readValid, access_err, burst_data, burst_valid,
           burst_last, burst_busy
  );
`endif
endinterface

// File: rtl/matrix_burst_ctrl.sv
// matrix_burst_ctrl: row/column stream sequencer. Produces the fetch address
// for the element that must appear on burst_data after the next edge, so the
// stream runs with no bubbles while ready stays high.
module matrix_burst_ctrl
  import matrix_mem_pkg::*;
#(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int RA_W = 4,
  parameter int CA_W = 4,
  parameter int IW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [IW-1:0]   idx_i,
  input  logic            ready_i,
  input  logic            block_i,
  output logic            fetch_o,
  output logic [RA_W-1:0] frow_o,
  output logic [CA_W-1:0] fcol_o,
  output logic            valid_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            err_o
);
  localparam logic [IW:0]   ROW_LIM = ROWS[IW:0];
  localparam logic [IW:0]   COL_LIM = COLS[IW:0];
  localparam logic [IW-1:0] ROW_END = IW'(COLS - 1);  // row stream walks columns
  localparam logic [IW-1:0] COL_END = IW'(ROWS - 1);  // column stream walks rows

  burst_state_t  state_q;
  burst_mode_t   mode_q, fmode;
  logic [IW-1:0] idx_q, pos_q, fidx, fpos;
  logic          valid_q;

  wire idx_ok = mode_i ? ({1'b0, idx_i} < COL_LIM) : ({1'b0, idx_i} < ROW_LIM);
  wire req    = start_i && !block_i && (state_q == IDLE);
  wire accept = req && idx_ok;
  wire at_end = pos_q == ((mode_q == ROW_MODE) ? ROW_END : COL_END);

  assign err_o   = req && !idx_ok;
  assign valid_o = valid_q;
  assign last_o  = valid_q && at_end;
  assign busy_o  = (state_q != IDLE);

  // Pick the element to load: element 0 on accept, pos+1 on a non-final handshake.
  always_comb begin
    fetch_o = 1'b0;
    fmode   = mode_q;
    fidx    = idx_q;
    fpos    = '0;
    if (accept) begin
      fetch_o = 1'b1;
      fmode   = burst_mode_t'(mode_i);
      fidx    = idx_i;
    end else if (valid_q && ready_i && !at_end) begin
      fetch_o = 1'b1;
      fpos    = pos_q + 1'b1;
    end
    frow_o = (fmode == ROW_MODE) ? fidx[RA_W-1:0] : fpos[RA_W-1:0];
    fcol_o = (fmode == ROW_MODE) ? fpos[CA_W-1:0] : fidx[CA_W-1:0];
  end

  // Burst FSM with registered valid; position advances only on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ROW_MODE;
      idx_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= STREAM;
          mode_q  <= burst_mode_t'(mode_i);
          idx_q   <= idx_i;
          pos_q   <= '0;
          valid_q <= 1'b1;
        end
        STREAM: if (ready_i) begin
          if (at_end) begin
            state_q <= IDLE;
            pos_q   <= '0;
            valid_q <= 1'b0;
          end else begin
            pos_q <= pos_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/matrix_mem_rc.sv
// matrix_mem_rc: ROWS x COLS element store with a registered element port and
// a row/column burst streamer. Define MATRIX_CLEAR_EN for the row-clear engine.
module matrix_mem_rc
  import matrix_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 10,
  parameter int COLS       = 10
) (
  input logic              clk,
  input logic              rst,
  matrix_mem_rc_if.slave   bus
);
  localparam int RA_W = clog2_min1(ROWS);
  localparam int CA_W = clog2_min1(COLS);
  localparam int IW   = (RA_W > CA_W) ? RA_W : CA_W;
  localparam logic [RA_W:0] ROW_LIM = ROWS[RA_W:0];
  localparam logic [CA_W:0] COL_LIM = COLS[CA_W:0];

  logic [DATA_WIDTH-1:0] mem_q [ROWS][COLS];
  logic [DATA_WIDTH-1:0] rd_data_q, bdata_q;
  logic                  rd_vld_q, err_q;
  logic                  b_fetch, b_busy, b_err, clr_busy;
  logic [RA_W-1:0]       frow;
  logic [CA_W-1:0]       fcol;

  wire addr_ok = ({1'b0, bus.rowAddr} < ROW_LIM) && ({1'b0, bus.colAddr} < COL_LIM);
  wire any_str = bus.en_WriteMat || bus.en_ReadMat;
  wire wr_ok   = bus.en_WriteMat && !bus.en_ReadMat && addr_ok && !clr_busy;
  wire rd_ok   = bus.en_ReadMat && !bus.en_WriteMat && addr_ok && !b_busy && !clr_busy;
  wire el_err  = any_str && !(wr_ok || rd_ok);
  wire clr_err = clr_busy && bus.burst_start;

  matrix_burst_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .RA_W(RA_W), .CA_W(CA_W), .IW(IW)
  ) u_burst (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.burst_start),
    .mode_i  (bus.burst_mode),
    .idx_i   (bus.burst_idx),
    .ready_i (bus.burst_ready),
    .block_i (clr_busy),
    .fetch_o (b_fetch),
    .frow_o  (frow),
    .fcol_o  (fcol),
    .valid_o (bus.burst_valid),
    .last_o  (bus.burst_last),
    .busy_o  (b_busy),
    .err_o   (b_err)
  );

`ifdef MATRIX_CLEAR_EN
  localparam logic [RA_W-1:0] ROW_LAST = RA_W'(ROWS - 1);
  logic            clr_busy_q;
  logic [RA_W-1:0] clr_row_q;

  // Row-by-row clear sequencer; only starts while the burst engine is quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_busy_q <= 1'b0;
      clr_row_q  <= '0;
    end else if (clr_busy_q) begin
      if (clr_row_q == ROW_LAST) begin
        clr_busy_q <= 1'b0;
        clr_row_q  <= '0;
      end else begin
        clr_row_q <= clr_row_q + 1'b1;
      end
    end else if (bus.clear_req && !b_busy && !bus.burst_start) begin
      clr_busy_q <= 1'b1;
    end
  end
  assign clr_busy       = clr_busy_q;
  assign bus.clear_busy = clr_busy_q;
`else
  assign clr_busy = 1'b0;
`endif

  // Storage: not reset; element writes and (optionally) row clears.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bus.rowAddr][bus.colAddr] <= bus.writeData;
`ifdef MATRIX_CLEAR_EN
    if (clr_busy_q)
      for (int c = 0; c < COLS; c++) mem_q[clr_row_q][c] <= '0;
`endif
  end

  // Registered read port, error pulse and burst data (reads see pre-write data).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      bdata_q   <= '0;
    end else begin
      rd_vld_q <= rd_ok;
      err_q    <= el_err || b_err || clr_err;
      if (rd_ok)   rd_data_q <= mem_q[bus.rowAddr][bus.colAddr];
      if (b_fetch) bdata_q   <= mem_q[frow][fcol];
    end
  end

  assign bus.readData   = rd_data_q;
  assign bus.readValid  = rd_vld_q;
  assign bus.access_err = err_q;
  assign bus.burst_data = bdata_q;
  assign bus.burst_busy = b_busy;
endmodule

// File: tb/tb_matrix_mem_rc.sv
// tb_matrix_mem_rc: table-driven element port checks plus scoreboarded bursts
// on a 10x10 and a non-square 4x6 instance.
module tb_matrix_mem_rc;
  import matrix_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_mem_rc_if #(.DATA_WIDTH(8), .ROWS(10), .COLS(10)) b0();
  matrix_mem_rc_if #(.DATA_WIDTH(8), .ROWS(4),  .COLS(6))  b1();

  matrix_mem_rc #(.DATA_WIDTH(8), .ROWS(10), .COLS(10)) u0 (.clk(clk), .rst(rst), .bus(b0));
  matrix_mem_rc #(.DATA_WIDTH(8), .ROWS(4),  .COLS(6))  u1 (.clk(clk), .rst(rst), .bus(b1));

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] d; logic l; } bexp_t;
  typedef struct {
    logic wr, rd; logic [3:0] r, c; logic [7:0] wd;
    logic err, rv; logic [7:0] rd_exp;
  } vec_t;

  logic [7:0] rdq0[$];
  bexp_t      bq0[$], bq1[$];
  vec_t       tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, rd, input int r, c, wd, input logic err, rv,
                              input int rexp);
    vec_t v;
    v.wr = wr; v.rd = rd; v.r = 4'(r); v.c = 4'(c); v.wd = 8'(wd);
    v.err = err; v.rv = rv; v.rd_exp = 8'(rexp);
    return v;
  endfunction

  // Scoreboard monitors: pop on each DUT output event, sampled mid-cycle.
  always @(negedge clk) begin : mon0
    bexp_t e;
    if (!rst) begin
      if (b0.readValid) begin
        chk("rdq0_empty_on_valid", rdq0.size() == 0, 0);
        if (rdq0.size() != 0) chk("readData", b0.readData, rdq0.pop_front());
      end
      if (b0.burst_valid && b0.burst_ready) begin
        chk("bq0_empty_on_hs", bq0.size() == 0, 0);
        if (bq0.size() != 0) begin
          e = bq0.pop_front();
          chk("burst_data0", b0.burst_data, e.d);
          chk("burst_last0", b0.burst_last, e.l);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    bexp_t e;
    if (!rst && b1.burst_valid && b1.burst_ready) begin
      chk("bq1_empty_on_hs", bq1.size() == 0, 0);
      if (bq1.size() != 0) begin
        e = bq1.pop_front();
        chk("burst_data1", b1.burst_data, e.d);
        chk("burst_last1", b1.burst_last, e.l);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [7:0] prev_d;
    logic prev_r;

    tv[0]  = mk(1, 0, 2, 2, 8'h11, 0, 0, 0);
    tv[1]  = mk(1, 0, 3, 7, 8'hA5, 0, 0, 0);
    tv[2]  = mk(0, 1, 3, 7, 0,     0, 1, 8'hA5);
    tv[3]  = mk(1, 1, 2, 2, 8'h33, 1, 0, 0);
    tv[4]  = mk(0, 1, 2, 2, 0,     0, 1, 8'h11);
    tv[5]  = mk(1, 0, 9, 9, 8'h99, 0, 0, 0);
    tv[6]  = mk(0, 1, 9, 9, 0,     0, 1, 8'h99);
    tv[7]  = mk(0, 1, 10, 9, 0,    1, 0, 0);
    tv[8]  = mk(1, 0, 10, 0, 8'hFF, 1, 0, 0);
    tv[9]  = mk(1, 0, 3, 12, 8'hEE, 1, 0, 0);
    tv[10] = mk(0, 1, 3, 7, 0,     0, 1, 8'hA5);
    tv[11] = mk(0, 1, 15, 15, 0,   1, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0,     0, 0, 0);

    {b0.en_WriteMat, b0.en_ReadMat, b0.rowAddr, b0.colAddr, b0.writeData} = '0;
    {b0.burst_start, b0.burst_mode, b0.burst_idx, b0.burst_ready} = '0;
    {b1.en_WriteMat, b1.en_ReadMat, b1.rowAddr, b1.colAddr, b1.writeData} = '0;
    {b1.burst_start, b1.burst_mode, b1.burst_idx, b1.burst_ready} = '0;

    repeat (2) tick();
    chk("rst_readData",    b0.readData,    0);
    chk("rst_readValid",   b0.readValid,   0);
    chk("rst_access_err",  b0.access_err,  0);
    chk("rst_burst_data",  b0.burst_data,  0);
    chk("rst_burst_valid", b0.burst_valid, 0);
    chk("rst_burst_last",  b0.burst_last,  0);
    chk("rst_burst_busy",  b0.burst_busy,  0);
    chk("rst_busy1",       b1.burst_busy,  0);
    rst = 1'b0;
    tick();

    // Element port table.
    for (int i = 0; i < 13; i++) begin
      b0.en_WriteMat = tv[i].wr; b0.en_ReadMat = tv[i].rd;
      b0.rowAddr = tv[i].r; b0.colAddr = tv[i].c; b0.writeData = tv[i].wd;
      if (tv[i].rv) rdq0.push_back(tv[i].rd_exp);
      tick();
      chk($sformatf("vec%0d_err", i), b0.access_err, tv[i].err);
      chk($sformatf("vec%0d_rv", i),  b0.readValid,  tv[i].rv);
    end

    // Fill both memories with r*16+c.
    b0.en_WriteMat = 1'b1; b1.en_WriteMat = 1'b1;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        b0.rowAddr = 4'(r); b0.colAddr = 4'(c); b0.writeData = 8'(r * 16 + c);
        b1.rowAddr = 2'(r); b1.colAddr = 3'(c); b1.writeData = 8'(r * 16 + c);
        b1.en_WriteMat = (r < 4) && (c < 6);
        tick();
      end
    b0.en_WriteMat = 1'b0; b1.en_WriteMat = 1'b0;

    // Row 4 with ready held high.
    for (int c = 0; c < 10; c++) bq0.push_back('{8'(8'h40 + c), c == 9});
    b0.burst_mode = 1'b0; b0.burst_idx = 4'd4; b0.burst_ready = 1'b1; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    chk("row_valid_lat", b0.burst_valid, 1);
    chk("row_busy", b0.burst_busy, 1);
    n = 0;
    while (b0.burst_valid && n < 40) begin n++; tick(); end
    chk("row_len", n, 10);
    chk("row_busy_fall", b0.burst_busy, 0);

    // Back-to-back start in the cycle busy falls: row 9.
    for (int c = 0; c < 10; c++) bq0.push_back('{8'(8'h90 + c), c == 9});
    b0.burst_idx = 4'd9; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    chk("b2b_valid", b0.burst_valid, 1);
    n = 0;
    while (b0.burst_valid && n < 40) begin n++; tick(); end
    chk("b2b_len", n, 10);

    // Element read blocked while a stalled burst is busy.
    for (int c = 0; c < 10; c++) bq0.push_back('{8'(c), c == 9});
    b0.burst_idx = 4'd0; b0.burst_ready = 1'b0; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    b0.en_ReadMat = 1'b1; b0.rowAddr = 4'd1; b0.colAddr = 4'd1;
    tick();
    b0.en_ReadMat = 1'b0;
    chk("blk_rd_err", b0.access_err, 1);
    chk("blk_rd_rv", b0.readValid, 0);
    chk("stall_data", b0.burst_data, 8'h00);
    b0.burst_ready = 1'b1;
    n = 0;
    while (b0.burst_valid && n < 40) begin n++; tick(); end
    chk("stall_drain_busy", b0.burst_busy, 0);

    // Column 2 with ready toggling.
    for (int r = 0; r < 10; r++) bq0.push_back('{8'(r * 16 + 2), r == 9});
    b0.burst_mode = 1'b1; b0.burst_idx = 4'd2; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    n = 0;
    while (b0.burst_valid && n < 80) begin
      b0.burst_ready = ~b0.burst_ready;
      prev_d = b0.burst_data; prev_r = b0.burst_ready;
      n++; tick();
      if (!prev_r && b0.burst_valid) chk("col_hold", b0.burst_data, prev_d);
    end
    chk("col_q_drained", bq0.size(), 0);
    chk("col_busy_fall", b0.burst_busy, 0);
    b0.burst_ready = 1'b1;

    // Out-of-range row index on 10x10.
    b0.burst_mode = 1'b0; b0.burst_idx = 4'd10; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    chk("row_oor_err", b0.access_err, 1);
    chk("row_oor_idle", b0.burst_busy, 0);

    // Non-square 4x6: column 5 gives 4 elements; column 6 is rejected.
    for (int r = 0; r < 4; r++) bq1.push_back('{8'(r * 16 + 5), r == 3});
    b1.burst_mode = 1'b1; b1.burst_idx = 3'd5; b1.burst_ready = 1'b1; b1.burst_start = 1'b1;
    tick();
    b1.burst_start = 1'b0;
    n = 0;
    while (b1.burst_valid && n < 40) begin n++; tick(); end
    chk("ns_col_len", n, 4);
    b1.burst_idx = 3'd6; b1.burst_start = 1'b1;
    tick();
    b1.burst_start = 1'b0;
    chk("ns_col_oor_err", b1.access_err, 1);
    chk("ns_col_oor_idle", b1.burst_busy, 0);

    // Reset during element 3 of row 1.
    for (int c = 0; c < 10; c++) bq0.push_back('{8'(8'h10 + c), c == 9});
    b0.burst_mode = 1'b0; b0.burst_idx = 4'd1; b0.burst_start = 1'b1;
    tick();
    b0.burst_start = 1'b0;
    repeat (3) tick();
    chk("mid_elem3", b0.burst_data, 8'h13);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", b0.burst_valid, 0);
    chk("rst_mid_busy",  b0.burst_busy,  0);
    chk("rst_mid_data",  b0.burst_data,  0);
    chk("rst_mid_last",  b0.burst_last,  0);
    bq0.delete();
    tick();
    rst = 1'b0;
    b0.en_ReadMat = 1'b1; b0.rowAddr = 4'd3; b0.colAddr = 4'd7;
    rdq0.push_back(8'h37);
    tick();
    b0.en_ReadMat = 1'b0;
    chk("post_rst_rv", b0.readValid, 1);
    tick();

    chk("rdq0_final", rdq0.size(), 0);
    chk("bq0_final",  bq0.size(),  0);
    chk("bq1_final",  bq1.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
